// File: rtl/cursor_control.sv
// Cursor, deferred-wrap and scroll-region owner between the command parser and the text RAM writer.
// Latency: a command is accepted in IDLE; its cursor update and write/scroll pulse are registered one cycle later.
// Backpressure: cmd_ready is high only in IDLE; it stays low while a scroll is outstanding, until scroll_done arrives.
module cursor_control #(
  parameter int LINES   = 30,
  parameter int COLUMNS = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_code,
  input  logic [7:0] pn1,
  input  logic [7:0] pn2,
  output logic [7:0] cursor_row,
  output logic [7:0] cursor_col,
  output logic       text_valid,
  output logic [7:0] text_row,
  output logic [7:0] text_col,
  output logic [7:0] text_char,
  output logic       scroll_valid,
  output logic [7:0] scroll_top,
  output logic [7:0] scroll_bottom,
  output logic [7:0] scroll_step,
  output logic       scroll_dir,
  input  logic       scroll_done
);

  localparam logic [7:0] LAST_ROW  = 8'(LINES - 1);
  localparam logic [7:0] LAST_COL  = 8'(COLUMNS - 1);
  localparam logic [8:0] LAST_ROW9 = 9'(LINES - 1);
  localparam logic [8:0] LAST_COL9 = 9'(COLUMNS - 1);

  localparam logic [3:0] C_INPUT = 4'd1, C_CR  = 4'd2,  C_LF  = 4'd3,  C_BS      = 4'd4;
  localparam logic [3:0] C_CUU   = 4'd5, C_CUD = 4'd6,  C_CUF = 4'd7,  C_CUB     = 4'd8;
  localparam logic [3:0] C_CUP   = 4'd9, C_RI  = 4'd10, C_DECSTBM = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SCROLL_WAIT, S_PRINT} state_e;

  state_e     state_q, state_d;
  logic [3:0] code_q, code_d;
  logic [7:0] p1_q, p1_d, p2_q, p2_d;
  logic [7:0] row_q, row_d, col_q, col_d, top_q, top_d, bot_q, bot_d;
  logic       wrap_q, wrap_d, pend_q, pend_d;
  logic       tv_q, tv_d, sv_q, sv_d, sdir_q, sdir_d;
  logic [7:0] trow_q, trow_d, tcol_q, tcol_d, tchar_q, tchar_d;

  // Saturating candidate positions for each command, computed in 9 bits.
  logic [8:0] row9, col9, n9, p1m9, p2m9, up9, dn9, cf9, lf9;
  logic [7:0] up_lim, dn_lim, cuu_row, cud_row, cuf_col, cub_col;
  logic [7:0] lf_row, ri_row, cup_row, cup_col, stbm_t, stbm_b;
  logic       in_region;

  assign row9      = {1'b0, row_q};
  assign col9      = {1'b0, col_q};
  assign n9        = (p1_q == 8'd0) ? 9'd1 : {1'b0, p1_q};
  assign p1m9      = (p1_q == 8'd0) ? 9'd0 : {1'b0, p1_q} - 9'd1;
  assign p2m9      = (p2_q == 8'd0) ? 9'd0 : {1'b0, p2_q} - 9'd1;
  assign in_region = (row_q >= top_q) && (row_q <= bot_q);

  assign up9     = (n9 > row9) ? 9'd0 : row9 - n9;
  assign up_lim  = in_region ? top_q : 8'd0;
  assign cuu_row = (up9 < {1'b0, up_lim}) ? up_lim : up9[7:0];
  assign dn9     = row9 + n9;
  assign dn_lim  = in_region ? bot_q : LAST_ROW;
  assign cud_row = (dn9 > {1'b0, dn_lim}) ? dn_lim : dn9[7:0];
  assign cf9     = col9 + n9;
  assign cuf_col = (cf9 > LAST_COL9) ? LAST_COL : cf9[7:0];
  assign cub_col = (n9 > col9) ? 8'd0 : col_q - n9[7:0];
  assign lf9     = row9 + 9'd1;
  assign lf_row  = (lf9 > LAST_ROW9) ? LAST_ROW : lf9[7:0];
  assign ri_row  = (row_q == 8'd0) ? 8'd0 : row_q - 8'd1;
  assign cup_row = (p1m9 > LAST_ROW9) ? LAST_ROW : p1m9[7:0];
  assign cup_col = (p2m9 > LAST_COL9) ? LAST_COL : p2m9[7:0];
  assign stbm_t  = p1m9[7:0];
  assign stbm_b  = (p2_q == 8'd0) ? LAST_ROW : ((p2m9 > LAST_ROW9) ? LAST_ROW : p2m9[7:0]);

  // Next-state logic: command capture, execution and the scroll handshake.
  always_comb begin
    state_d = state_q;  code_d = code_q;  p1_d = p1_q;  p2_d = p2_q;
    row_d   = row_q;    col_d  = col_q;   top_d = top_q; bot_d = bot_q;
    wrap_d  = wrap_q;   pend_d = pend_q;
    tv_d    = 1'b0;     sv_d   = 1'b0;    sdir_d = sdir_q;
    trow_d  = trow_q;   tcol_d = tcol_q;  tchar_d = tchar_q;
    cmd_ready = (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          code_d  = cmd_code;
          p1_d    = pn1;
          p2_d    = pn2;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (code_q)
          C_INPUT: begin
            if (p1_q >= 8'h20) begin
              if (!wrap_q) begin
                tv_d = 1'b1;  trow_d = row_q;  tcol_d = col_q;  tchar_d = p1_q;
                if (col_q == LAST_COL) wrap_d = 1'b1;
                else                   col_d  = col_q + 8'd1;
              end else begin
                // Deferred wrap: CR, LF, then print at column 0.
                wrap_d = 1'b0;
                col_d  = 8'd0;
                if (row_q == bot_q) begin
                  sv_d = 1'b1;  sdir_d = 1'b0;  pend_d = 1'b1;
                  state_d = S_SCROLL_WAIT;
                end else begin
                  row_d = lf_row;
                  tv_d  = 1'b1;  trow_d = lf_row;  tcol_d = 8'd0;  tchar_d = p1_q;
                  col_d = 8'd1;
                end
              end
            end
          end
          C_CR: begin wrap_d = 1'b0; col_d = 8'd0; end
          C_LF: begin
            wrap_d = 1'b0;
            if (row_q == bot_q) begin
              sv_d = 1'b1;  sdir_d = 1'b0;  pend_d = 1'b0;
              state_d = S_SCROLL_WAIT;
            end else begin
              row_d = lf_row;
            end
          end
          C_RI: begin
            wrap_d = 1'b0;
            if (row_q == top_q) begin
              sv_d = 1'b1;  sdir_d = 1'b1;  pend_d = 1'b0;
              state_d = S_SCROLL_WAIT;
            end else begin
              row_d = ri_row;
            end
          end
          C_BS:  begin wrap_d = 1'b0; col_d = cub_col; end
          C_CUB: begin wrap_d = 1'b0; col_d = cub_col; end
          C_CUF: begin wrap_d = 1'b0; col_d = cuf_col; end
          C_CUU: begin wrap_d = 1'b0; row_d = cuu_row; end
          C_CUD: begin wrap_d = 1'b0; row_d = cud_row; end
          C_CUP: begin wrap_d = 1'b0; row_d = cup_row; col_d = cup_col; end
          C_DECSTBM: begin
            if (stbm_t < stbm_b) begin
              top_d = stbm_t;  bot_d = stbm_b;
              row_d = 8'd0;    col_d = 8'd0;  wrap_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
      S_SCROLL_WAIT: begin
        if (scroll_done) begin
          if (pend_q) begin
            pend_d = 1'b0;
            tv_d   = 1'b1;  trow_d = row_q;  tcol_d = 8'd0;  tchar_d = p1_q;
            col_d  = 8'd1;
            state_d = S_PRINT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_PRINT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any scroll wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  code_q <= 4'd0;  p1_q <= 8'd0;  p2_q <= 8'd0;
      row_q   <= 8'd0;    col_q  <= 8'd0;  top_q <= 8'd0; bot_q <= LAST_ROW;
      wrap_q  <= 1'b0;    pend_q <= 1'b0;
      tv_q    <= 1'b0;    sv_q   <= 1'b0;  sdir_q <= 1'b0;
      trow_q  <= 8'd0;    tcol_q <= 8'd0;  tchar_q <= 8'd0;
    end else begin
      state_q <= state_d; code_q <= code_d; p1_q <= p1_d;  p2_q <= p2_d;
      row_q   <= row_d;   col_q  <= col_d;  top_q <= top_d; bot_q <= bot_d;
      wrap_q  <= wrap_d;  pend_q <= pend_d;
      tv_q    <= tv_d;    sv_q   <= sv_d;   sdir_q <= sdir_d;
      trow_q  <= trow_d;  tcol_q <= tcol_d; tchar_q <= tchar_d;
    end
  end

  assign cursor_row    = row_q;
  assign cursor_col    = col_q;
  assign text_valid    = tv_q;
  assign text_row      = trow_q;
  assign text_col      = tcol_q;
  assign text_char     = tchar_q;
  assign scroll_valid  = sv_q;
  assign scroll_top    = top_q;
  assign scroll_bottom = bot_q;
  assign scroll_step   = 8'd1;
  assign scroll_dir    = sdir_q;

endmodule

// File: tb/tb_cursor_control.sv
// Scoreboard bench for cursor_control: expected writes/scrolls queued at stimulus time, popped on DUT pulses.
// Cursor position and region are checked against constants after each command retires.
// Scroll completion is driven by hand so the stall window can be observed.
module tb_cursor_control;

  localparam logic [3:0] NOP = 4'd0, INPUT = 4'd1, CR = 4'd2, LF = 4'd3, BS = 4'd4;
  localparam logic [3:0] CUU = 4'd5, CUD = 4'd6, CUF = 4'd7, CUB = 4'd8;
  localparam logic [3:0] CUP = 4'd9, RI = 4'd10, DECSTBM = 4'd11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_code = 4'd0;
  logic [7:0] pn1 = 8'd0, pn2 = 8'd0;
  logic [7:0] cursor_row, cursor_col;
  logic       text_valid;
  logic [7:0] text_row, text_col, text_char;
  logic       scroll_valid;
  logic [7:0] scroll_top, scroll_bottom, scroll_step;
  logic       scroll_dir;
  logic       scroll_done = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [23:0] exp_text[$];    // {row, col, char}
  logic [24:0] exp_scroll[$];  // {top, bottom, step, dir}
  logic [23:0] te;
  logic [24:0] se;

  cursor_control #(.LINES(30), .COLUMNS(80)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .pn1(pn1), .pn2(pn2),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .text_valid(text_valid), .text_row(text_row), .text_col(text_col), .text_char(text_char),
    .scroll_valid(scroll_valid), .scroll_top(scroll_top), .scroll_bottom(scroll_bottom),
    .scroll_step(scroll_step), .scroll_dir(scroll_dir), .scroll_done(scroll_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every pulse must match the head of its queue.
  always @(negedge clk) begin
    if (text_valid) begin
      if (exp_text.size() == 0) check("text_unexpected", {8'd0, text_row, text_col, text_char}, 32'd0);
      else begin
        te = exp_text.pop_front();
        check("text", {8'd0, text_row, text_col, text_char}, {8'd0, te});
      end
    end
    if (scroll_valid) begin
      if (exp_scroll.size() == 0) check("scroll_unexpected", {7'd0, scroll_top, scroll_bottom, scroll_step, scroll_dir}, 32'd0);
      else begin
        se = exp_scroll.pop_front();
        check("scroll", {7'd0, scroll_top, scroll_bottom, scroll_step, scroll_dir}, {7'd0, se});
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = c; pn1 = a; pn2 = b;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    check("accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("idle", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic pulse_done();
    @(negedge clk); scroll_done = 1'b1;
    @(negedge clk); scroll_done = 1'b0;
  endtask

  task automatic expect_pos(input string tag, input logic [7:0] r, input logic [7:0] c);
    check({tag, "_row"}, {24'd0, cursor_row}, {24'd0, r});
    check({tag, "_col"}, {24'd0, cursor_col}, {24'd0, c});
  endtask

  task automatic cmd(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    send(c, a, b);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    expect_pos("reset", 8'd0, 8'd0);
    check("reset_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_tv", {31'd0, text_valid}, 32'd0);
    check("reset_sv", {31'd0, scroll_valid}, 32'd0);
    check("reset_bot", {24'd0, scroll_bottom}, 32'd29);
    check("reset_top", {24'd0, scroll_top}, 32'd0);
    check("step", {24'd0, scroll_step}, 32'd1);
    rst_n = 1'b1;

    // First print and its latency
    exp_text.push_back({8'd0, 8'd0, 8'h41});
    send(INPUT, 8'h41, 8'd0);
    @(negedge clk);
    check("A_latency", {31'd0, text_valid}, 32'd1);
    wait_idle();
    expect_pos("A", 8'd0, 8'd1);

    // Cursor moves and clamps
    cmd(CUP, 8'd0, 8'd0);    expect_pos("cup00", 8'd0, 8'd0);
    cmd(CUF, 8'd200, 8'd0);  expect_pos("cuf200", 8'd0, 8'd79);
    cmd(CUB, 8'd0, 8'd0);    expect_pos("cub0", 8'd0, 8'd78);
    cmd(CUP, 8'd31, 8'd90);  expect_pos("cup3190", 8'd29, 8'd79);

    // Deferred wrap mid-screen
    cmd(CUP, 8'd6, 8'd80);
    exp_text.push_back({8'd5, 8'd79, 8'h78});
    cmd(INPUT, 8'h78, 8'd0); expect_pos("wrap_set", 8'd5, 8'd79);
    exp_text.push_back({8'd6, 8'd0, 8'h42});
    cmd(INPUT, 8'h42, 8'd0); expect_pos("wrap_B", 8'd6, 8'd1);
    cmd(INPUT, 8'h0A, 8'd0); expect_pos("ctrl_ign", 8'd6, 8'd1);
    cmd(BS, 8'd0, 8'd0);     expect_pos("bs1", 8'd6, 8'd0);
    cmd(BS, 8'd0, 8'd0);     expect_pos("bs_sat", 8'd6, 8'd0);
    cmd(NOP, 8'd0, 8'd0);    expect_pos("nop", 8'd6, 8'd0);

    // Scroll region and LF scroll with held command
    cmd(DECSTBM, 8'd5, 8'd10);
    expect_pos("stbm_home", 8'd0, 8'd0);
    check("stbm_top", {24'd0, scroll_top}, 32'd4);
    check("stbm_bot", {24'd0, scroll_bottom}, 32'd9);
    cmd(CUP, 8'd10, 8'd1);   expect_pos("cup10", 8'd9, 8'd0);
    cmd(CUF, 8'd5, 8'd0);
    exp_scroll.push_back({8'd4, 8'd9, 8'd1, 1'b0});
    send(LF, 8'd0, 8'd0);
    fork
      send(CR, 8'd0, 8'd0);
      begin
        repeat (4) @(negedge clk);
        check("stall_ready", {31'd0, cmd_ready}, 32'd0);
        expect_pos("lf_scroll", 8'd9, 8'd5);
        pulse_done();
      end
    join
    wait_idle();
    expect_pos("held_cr", 8'd9, 8'd0);
    cmd(CUD, 8'd100, 8'd0);  expect_pos("cud_region", 8'd9, 8'd0);
    cmd(CUU, 8'd100, 8'd0);  expect_pos("cuu_region", 8'd4, 8'd0);

    // RI at top scrolls down
    exp_scroll.push_back({8'd4, 8'd9, 8'd1, 1'b1});
    send(RI, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    check("ri_ready", {31'd0, cmd_ready}, 32'd0);
    pulse_done();
    wait_idle();
    expect_pos("ri", 8'd4, 8'd0);

    // Inverted region is ignored
    cmd(CUP, 8'd7, 8'd3);
    cmd(DECSTBM, 8'd10, 8'd5);
    expect_pos("stbm_bad", 8'd6, 8'd2);
    check("stbm_bad_top", {24'd0, scroll_top}, 32'd4);
    check("stbm_bad_bot", {24'd0, scroll_bottom}, 32'd9);

    // Movement outside the region clamps to the screen
    cmd(CUP, 8'd2, 8'd1);    cmd(CUU, 8'd0, 8'd0);  expect_pos("cuu_out", 8'd0, 8'd0);
    cmd(CUP, 8'd20, 8'd1);   cmd(CUD, 8'd50, 8'd0); expect_pos("cud_out", 8'd29, 8'd0);
    cmd(LF, 8'd0, 8'd0);     expect_pos("lf_sat", 8'd29, 8'd0);
    pulse_done();
    check("done_ignored", {31'd0, cmd_ready}, 32'd1);

    // Wrap on the bottom row: scroll first, print after scroll_done
    cmd(CUP, 8'd10, 8'd80);
    exp_text.push_back({8'd9, 8'd79, 8'h79});
    cmd(INPUT, 8'h79, 8'd0);
    exp_scroll.push_back({8'd4, 8'd9, 8'd1, 1'b0});
    exp_text.push_back({8'd9, 8'd0, 8'h43});
    send(INPUT, 8'h43, 8'd0);
    repeat (3) @(negedge clk);
    check("print_pending", exp_text.size(), 32'd1);
    check("pending_ready", {31'd0, cmd_ready}, 32'd0);
    pulse_done();
    wait_idle();
    expect_pos("wrap_C", 8'd9, 8'd1);

    // Reset during a scroll wait
    cmd(CUP, 8'd10, 8'd80);
    exp_text.push_back({8'd9, 8'd79, 8'h79});
    cmd(INPUT, 8'h79, 8'd0);
    exp_scroll.push_back({8'd4, 8'd9, 8'd1, 1'b0});
    send(INPUT, 8'h44, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    expect_pos("rst_mid", 8'd0, 8'd0);
    check("rst_mid_top", {24'd0, scroll_top}, 32'd0);
    check("rst_mid_bot", {24'd0, scroll_bottom}, 32'd29);
    rst_n = 1'b1;
    pulse_done();
    repeat (3) @(negedge clk);
    check("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
    expect_pos("rst_after", 8'd0, 8'd0);

    check("text_q_empty", exp_text.size(), 32'd0);
    check("scroll_q_empty", exp_scroll.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
